// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared constants, destination record type and match helper for the hazard scoreboard
package hazard_pkg;

  // Register index width used by the destination record.
  localparam int REG_AW_DFLT = 5;

  // Number of cycles HI/LO stays busy after a mult/div issues.
  localparam int MULDIV_LAT_DFLT = 4;

  // Operand source selects presented to the EX-stage operand muxes.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // One in-flight instruction's destination as seen by the scoreboard.
  typedef struct packed {
    logic [REG_AW_DFLT-1:0] rd;
    logic                   wr_valid;
    logic                   is_load;
  } dest_rec_t;

  // Reads of a source operand hit a record only if that record really writes.
  // wr_valid is never set for $0, so $0 can never hit.
  function automatic logic rec_match(input logic [REG_AW_DFLT-1:0] src,
                                     input logic uses,
                                     input dest_rec_t rec);
    return uses & rec.wr_valid & (src == rec.rd);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - ID-stage request and hazard/forwarding response bundle
interface hazard_scoreboard_if
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DFLT
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_muldiv;
  logic              id_hilo_read;
  logic              flush;
  logic              stall;
  logic              bubble;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic              muldiv_busy;

  // Pipeline control side: presents the ID instruction, consumes stall/forwarding.
  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
           id_reg_write, id_mem_read, id_muldiv, id_hilo_read, flush,
    input  stall, bubble, fwd_a_sel, fwd_b_sel, muldiv_busy
  );

  // Scoreboard side.
  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
           id_reg_write, id_mem_read, id_muldiv, id_hilo_read, flush,
    output stall, bubble, fwd_a_sel, fwd_b_sel, muldiv_busy
  );
endinterface

// File: rtl/muldiv_busy_ctr.sv
// rtl/muldiv_busy_ctr.sv - HI/LO busy down-counter, reloaded on every issued mult/div
module muldiv_busy_ctr
  import hazard_pkg::*;
#(
  parameter int LAT = MULDIV_LAT_DFLT
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic busy_o
);
  localparam int W = $clog2(LAT + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Reload wins over decrement so back-to-back mult/div extends the busy window.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = W'(LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight destination tracking, load-use stall and registered forwarding selects (optional HI/LO interlock: MULDIV_BUSY_EN)
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW     = REG_AW_DFLT,
  parameter int MULDIV_LAT = MULDIV_LAT_DFLT
) (
  input  logic                clk,
  input  logic                rst,
  hazard_scoreboard_if.slave  hz
);
  dest_rec_t  id_rec;
  dest_rec_t  ex_q;
  dest_rec_t  mem_q;
  dest_rec_t  wb_q;
  logic [1:0] fwd_a_q;
  logic [1:0] fwd_a_d;
  logic [1:0] fwd_b_q;
  logic [1:0] fwd_b_d;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic       load_use;
  logic       hilo_hazard;
  logic       busy;
  logic       stall;
  logic       bubble;
  logic       unused_ok;

  assign rs = hz.id_rs;
  assign rt = hz.id_rt;

  // Record for the instruction in ID; a write to $0 is treated as no write.
  always_comb begin
    id_rec          = '0;
    id_rec.rd       = hz.id_rd;
    id_rec.wr_valid = hz.id_reg_write & (hz.id_rd != '0);
    id_rec.is_load  = hz.id_mem_read;
  end

  // Load-use: the load's data only exists after MEM, so a reader right behind it must wait.
  assign load_use = hz.id_valid & ex_q.is_load &
                    (rec_match(rs, hz.id_uses_rs, ex_q) | rec_match(rt, hz.id_uses_rt, ex_q));

`ifdef MULDIV_BUSY_EN
  muldiv_busy_ctr #(
    .LAT (MULDIV_LAT)
  ) u_busy_ctr (
    .clk    (clk),
    .rst    (rst),
    .load_i (hz.id_muldiv & ~bubble),
    .busy_o (busy)
  );
  assign hilo_hazard = hz.id_valid & hz.id_hilo_read & busy;
`else
  assign busy        = 1'b0;
  assign hilo_hazard = 1'b0;
`endif

  // A taken branch kills the ID instruction, so there is nothing left to stall.
  assign stall  = (load_use | hilo_hazard) & ~hz.flush;
  assign bubble = stall | hz.flush | ~hz.id_valid;

  // Select computed against today's EX/MEM, which are MEM/WB when this instruction reaches EX.
  always_comb begin
    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    if (!bubble) begin
      if (rec_match(rs, hz.id_uses_rs, ex_q)) begin
        fwd_a_d = FWD_MEM;
      end else if (rec_match(rs, hz.id_uses_rs, mem_q)) begin
        fwd_a_d = FWD_WB;
      end
      if (rec_match(rt, hz.id_uses_rt, ex_q)) begin
        fwd_b_d = FWD_MEM;
      end else if (rec_match(rt, hz.id_uses_rt, mem_q)) begin
        fwd_b_d = FWD_WB;
      end
    end
  end

  // Record shift and select registers advance every edge; a bubble enters EX as an empty record.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      wb_q    <= mem_q;
      mem_q   <= ex_q;
      ex_q    <= bubble ? dest_rec_t'('0) : id_rec;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign hz.stall       = stall;
  assign hz.bubble      = bubble;
  assign hz.fwd_a_sel   = fwd_a_q;
  assign hz.fwd_b_sel   = fwd_b_q;
  assign hz.muldiv_busy = busy;

  // WB record and the HI/LO inputs are kept for visibility even when no logic consumes them.
  assign unused_ok = ^{wb_q, mem_q.is_load, hz.id_muldiv, hz.id_hilo_read, (MULDIV_LAT != 0)};

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed scoreboard bench for hazard_scoreboard (expectations follow MULDIV_BUSY_EN)
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [3:0] exp_q[$];

  hazard_scoreboard_if hz_if ();

  hazard_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one ID instruction for one cycle; check stall/bubble before the edge, selects after it.
  task automatic step(input string tag, input logic v, input int rs, input int rt,
                      input logic urs, input logic urt, input int rd, input logic rw,
                      input logic mr, input logic md, input logic hr, input logic fl,
                      input logic es, input logic [1:0] ea, input logic [1:0] eb);
    logic eb_bub;
    logic [3:0] e;
    hz_if.id_valid     = v;
    hz_if.id_rs        = rs[4:0];
    hz_if.id_rt        = rt[4:0];
    hz_if.id_uses_rs   = urs;
    hz_if.id_uses_rt   = urt;
    hz_if.id_rd        = rd[4:0];
    hz_if.id_reg_write = rw;
    hz_if.id_mem_read  = mr;
    hz_if.id_muldiv    = md;
    hz_if.id_hilo_read = hr;
    hz_if.flush        = fl;
    #1;
    eb_bub = es | fl | ~v;
    chk({tag, ".stall"}, {7'd0, hz_if.stall}, {7'd0, es});
    chk({tag, ".bubble"}, {7'd0, hz_if.bubble}, {7'd0, eb_bub});
    exp_q.push_back(eb_bub ? 4'b0000 : {ea, eb});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, ".queue_empty"}, 8'd0, 8'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".fwd_a"}, {6'd0, hz_if.fwd_a_sel}, {6'd0, e[3:2]});
      chk({tag, ".fwd_b"}, {6'd0, hz_if.fwd_b_sel}, {6'd0, e[1:0]});
    end
  endtask

  task automatic nop();
    step("nop", 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, FWD_RF, FWD_RF);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    hz_if.id_valid = 1'b0; hz_if.id_rs = '0; hz_if.id_rt = '0;
    hz_if.id_uses_rs = 1'b0; hz_if.id_uses_rt = 1'b0; hz_if.id_rd = '0;
    hz_if.id_reg_write = 1'b0; hz_if.id_mem_read = 1'b0; hz_if.id_muldiv = 1'b0;
    hz_if.id_hilo_read = 1'b0; hz_if.flush = 1'b0;
    #12;
    chk("reset.stall", {7'd0, hz_if.stall}, 8'd0);
    chk("reset.bubble", {7'd0, hz_if.bubble}, 8'd1);
    chk("reset.fwd_a", {6'd0, hz_if.fwd_a_sel}, 8'd0);
    chk("reset.fwd_b", {6'd0, hz_if.fwd_b_sel}, 8'd0);
    chk("reset.busy", {7'd0, hz_if.muldiv_busy}, 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // add $3,$1,$2 ; add $4,$3,$3
    step("t1.add3", 1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, FWD_RF, FWD_RF);
    step("t1.add4", 1, 3, 3, 1, 1, 4, 1, 0, 0, 0, 0, 0, FWD_MEM, FWD_MEM);
    nop(); nop();

    // lw $5,0($1) ; sub $6,$5,$2 (one stall, then WB bypass)
    step("t2.lw", 1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, FWD_RF, FWD_RF);
    step("t2.sub_stall", 1, 5, 2, 1, 1, 6, 1, 0, 0, 0, 0, 1, FWD_RF, FWD_RF);
    step("t2.sub_go", 1, 5, 2, 1, 1, 6, 1, 0, 0, 0, 0, 0, FWD_WB, FWD_RF);
    nop(); nop();

    // addi $0,$1,7 ; add $2,$0,$0
    step("t3.addi0", 1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, FWD_RF, FWD_RF);
    step("t3.add0", 1, 0, 0, 1, 1, 2, 1, 0, 0, 0, 0, 0, FWD_RF, FWD_RF);
    nop(); nop();

    // add $7 ; add $7 ; or $8,$7,$7 (newest producer wins)
    step("t4.add7a", 1, 1, 2, 1, 1, 7, 1, 0, 0, 0, 0, 0, FWD_RF, FWD_RF);
    step("t4.add7b", 1, 1, 2, 1, 1, 7, 1, 0, 0, 0, 0, 0, FWD_RF, FWD_RF);
    step("t4.or8", 1, 7, 7, 1, 1, 8, 1, 0, 0, 0, 0, 0, FWD_MEM, FWD_MEM);
    nop(); nop();

    // add $9 ; nop ; and $10,$9,$1 (WB bypass only)
    step("t4.add9", 1, 1, 2, 1, 1, 9, 1, 0, 0, 0, 0, 0, FWD_RF, FWD_RF);
    nop();
    step("t4.and10", 1, 9, 1, 1, 1, 10, 1, 0, 0, 0, 0, 0, FWD_WB, FWD_RF);
    nop(); nop();

    // lw $5 ; dependant flushed in the same cycle ; add $11,$6,$5
    step("t5.lw", 1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, FWD_RF, FWD_RF);
    step("t5.flush", 1, 5, 2, 1, 1, 6, 1, 0, 0, 0, 1, 0, FWD_RF, FWD_RF);
    step("t5.after", 1, 6, 5, 1, 1, 11, 1, 0, 0, 0, 0, 0, FWD_RF, FWD_WB);
    nop(); nop();

    // mult $1,$2 ; mfhi $12
    step("t6.mult", 1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 0, 0, FWD_RF, FWD_RF);
`ifdef MULDIV_BUSY_EN
    chk("t6.busy_set", {7'd0, hz_if.muldiv_busy}, 8'd1);
    for (int k = 0; k < 4; k++) begin
      step("t6.mfhi_stall", 1, 0, 0, 0, 0, 12, 1, 0, 0, 1, 0, 1, FWD_RF, FWD_RF);
      chk("t6.busy_cnt", {7'd0, hz_if.muldiv_busy}, (k < 3) ? 8'd1 : 8'd0);
    end
`else
    chk("t6.busy_off", {7'd0, hz_if.muldiv_busy}, 8'd0);
`endif
    step("t6.mfhi_go", 1, 0, 0, 0, 0, 12, 1, 0, 0, 1, 0, 0, FWD_RF, FWD_RF);
    chk("t6.busy_clr", {7'd0, hz_if.muldiv_busy}, 8'd0);
    nop(); nop();

    // add $13 ; mult $13,$13 ; async reset mid-count ; mfhi no longer stalls
    step("t7.add13", 1, 1, 2, 1, 1, 13, 1, 0, 0, 0, 0, 0, FWD_RF, FWD_RF);
    step("t7.mult", 1, 13, 13, 1, 1, 0, 0, 0, 1, 0, 0, 0, FWD_MEM, FWD_MEM);
`ifdef MULDIV_BUSY_EN
    chk("t7.busy_pre", {7'd0, hz_if.muldiv_busy}, 8'd1);
`endif
    hz_if.id_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("t7.rst_busy", {7'd0, hz_if.muldiv_busy}, 8'd0);
    chk("t7.rst_fwd_a", {6'd0, hz_if.fwd_a_sel}, 8'd0);
    chk("t7.rst_fwd_b", {6'd0, hz_if.fwd_b_sel}, 8'd0);
    chk("t7.rst_stall", {7'd0, hz_if.stall}, 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("t7.mfhi", 1, 0, 0, 0, 0, 12, 1, 0, 0, 1, 0, 0, FWD_RF, FWD_RF);
    step("t7.use13", 1, 13, 0, 1, 0, 14, 1, 0, 0, 0, 0, 0, FWD_RF, FWD_RF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
